// File: rtl/stream_calc_q_pkg.sv
// stream_calc_pkg: opcodes, error codes, FSM state type and count-width helper
// shared by the stream calculator, its interface and the testbench.
// Optional build macro used elsewhere: STREAMCALC_SAT_EN (saturating ADD/SUB/MUL).
package stream_calc_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_FRAC = 3'd4;
    localparam logic [2:0] OP_PUSH = 3'd5;
    localparam logic [2:0] OP_POP  = 3'd6;
    localparam logic [2:0] OP_BAD  = 3'd7;

    localparam logic [1:0] ERR_OP    = 2'd0;
    localparam logic [1:0] ERR_EMPTY = 2'd1;
    localparam logic [1:0] ERR_FULL  = 2'd2;
    localparam logic [1:0] ERR_DIV0  = 2'd3;

    // DIV2 is the remainder (fraction) pass, only entered by FRAC.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV1 = 2'd1,
        DIV2 = 2'd2
    } state_t;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_calc_q_if.sv
// Stream calculator bus: command side (apply/op/in) and result/status side.
// Handshake: an op is taken on a rising edge when apply=1, busy=0 and err=0;
// otherwise apply has no effect. out_valid pulses for one cycle when out updates.
// state mirrors the control FSM for observation only.
interface stream_calc_q_if #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) ();
    import stream_calc_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic          apply;
    logic [2:0]    op;
    logic [W-1:0]  in;
    logic [W-1:0]  out;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          err;
    logic [1:0]    err_code;
    state_t        state;

    modport master (
        output apply, op, in,
        input  out, out_valid, busy, count, empty, full, err, err_code, state
    );

    modport slave (
        input  apply, op, in,
        output out, out_valid, busy, count, empty, full, err, err_code, state
    );

endinterface

// File: rtl/stream_calc_q_divider.sv
// sc_divider: W-bit restoring divider, one quotient bit per cycle.
// rem_init seeds the partial remainder so a second pass with dividend=0
// produces the binary fraction of a previous remainder. done, quotient and
// remainder are presented during the final iteration cycle, so a caller can
// commit the result on the same edge that finishes the division.
module sc_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic [W-1:0] rem_init,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int NW = $clog2(W) + 1;

    logic [W-1:0]  dq;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic [NW-1:0] cnt;
    logic          running;

    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  dq_nx;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem, dq[W-1]};
        ge      = (shifted >= {1'b0, dvs});
        rem_nx  = ge ? W'(shifted - {1'b0, dvs}) : shifted[W-1:0];
        dq_nx   = {dq[W-2:0], ge};
    end

    assign done      = running && (cnt == NW'(W - 1));
    assign quotient  = dq_nx;
    assign remainder = rem_nx;

    // Iteration registers; start always wins so a pass can chain into the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq      <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            dq      <= dividend;
            rem     <= rem_init;
            dvs     <= divisor;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            dq  <= dq_nx;
            rem <= rem_nx;
            cnt <= cnt + NW'(1);
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_calc_q.sv
// stream_calc_q: FIFO operand queue with a one-op-per-cycle calculator and an
// iterative divider. Binary ops consume head (a) and next (b), append result.
// Build macro STREAMCALC_SAT_EN makes ADD/SUB/MUL saturate instead of wrap.
module stream_calc_q
    import stream_calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    stream_calc_q_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          is_frac;
    logic [W-1:0]  dvs_q;
    logic [W-1:0]  out_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          accept;
    logic          bad;
    logic [1:0]    code;
    logic [W-1:0]  alu_res;

    logic          div_start;
    logic          div_done;
    logic [W-1:0]  div_quo;
    logic [W-1:0]  div_rem;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic [W-1:0]  div_rem_init;

    assign a      = mem[head];
    assign b      = mem[head + AW'(1)];
    assign accept = bus.apply && !busy_q && !err_q;

    // Error classification of the presented op, first match wins.
    always_comb begin
        bad  = 1'b0;
        code = ERR_OP;
        if (bus.op == OP_BAD) begin
            bad = 1'b1; code = ERR_OP;
        end else if (bus.op == OP_POP && cnt == '0) begin
            bad = 1'b1; code = ERR_EMPTY;
        end else if (bus.op <= OP_FRAC && cnt < CW'(2)) begin
            bad = 1'b1; code = ERR_EMPTY;
        end else if (bus.op == OP_PUSH && cnt == CW'(DEPTH)) begin
            bad = 1'b1; code = ERR_FULL;
        end else if ((bus.op == OP_DIV || bus.op == OP_FRAC) && b == '0) begin
            bad = 1'b1; code = ERR_DIV0;
        end
    end

`ifdef STREAMCALC_SAT_EN
    logic [W:0]     sum_w;
    logic [W:0]     diff_w;
    logic [2*W-1:0] prod_w;

    // Saturating single-cycle arithmetic: overflow clamps high, borrow clamps to 0.
    always_comb begin
        sum_w   = {1'b0, a} + {1'b0, b};
        diff_w  = {1'b0, a} - {1'b0, b};
        prod_w  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = sum_w[W] ? '1 : sum_w[W-1:0];
            OP_SUB:  alu_res = diff_w[W] ? '0 : diff_w[W-1:0];
            OP_MUL:  alu_res = (|prod_w[2*W-1:W]) ? '1 : prod_w[W-1:0];
            default: alu_res = '0;
        endcase
    end
`else
    // Wrapping single-cycle arithmetic, modulo 2^W.
    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_MUL:  alu_res = W'(a * b);
            default: alu_res = '0;
        endcase
    end
`endif

    // Divider launch: from IDLE on an accepted DIV/FRAC, or chained into the
    // fraction pass with the first pass's remainder and the saved divisor.
    always_comb begin
        div_start    = (accept && !bad && (bus.op == OP_DIV || bus.op == OP_FRAC)) ||
                       (state == DIV1 && is_frac && div_done);
        div_dividend = (state == IDLE) ? a  : '0;
        div_divisor  = (state == IDLE) ? b  : dvs_q;
        div_rem_init = (state == IDLE) ? '0 : div_rem;
    end

    sc_divider #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .rem_init  (div_rem_init),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Control FSM plus queue, pointers, occupancy and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            state       <= IDLE;
            is_frac     <= 1'b0;
            dvs_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_OP;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= code;
                        end else begin
                            case (bus.op)
                                OP_ADD, OP_SUB, OP_MUL: begin
                                    mem[tail] <= alu_res;
                                    head      <= head + AW'(2);
                                    tail      <= tail + AW'(1);
                                    cnt       <= cnt - CW'(1);
                                end
                                OP_DIV, OP_FRAC: begin
                                    head    <= head + AW'(2);
                                    cnt     <= cnt - CW'(2);
                                    dvs_q   <= b;
                                    is_frac <= (bus.op == OP_FRAC);
                                    busy_q  <= 1'b1;
                                    state   <= DIV1;
                                end
                                OP_PUSH: begin
                                    mem[tail] <= bus.in;
                                    tail      <= tail + AW'(1);
                                    cnt       <= cnt + CW'(1);
                                end
                                OP_POP: begin
                                    out_q       <= a;
                                    out_valid_q <= 1'b1;
                                    head        <= head + AW'(1);
                                    cnt         <= cnt - CW'(1);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                DIV1: begin
                    if (div_done) begin
                        if (is_frac) begin
                            state <= DIV2;
                        end else begin
                            mem[tail] <= div_quo;
                            tail      <= tail + AW'(1);
                            cnt       <= cnt + CW'(1);
                            busy_q    <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                DIV2: begin
                    if (div_done) begin
                        mem[tail] <= div_quo;
                        tail      <= tail + AW'(1);
                        cnt       <= cnt + CW'(1);
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.count     = cnt;
    assign bus.empty     = (cnt == '0);
    assign bus.full      = (cnt == CW'(DEPTH));
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_stream_calc_q.sv
// Directed bench for stream_calc_q: popped results are predicted into exp_q
// when a POP is issued; a negedge monitor pops and compares on out_valid.
module tb_stream_calc_q;
    import stream_calc_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    stream_calc_q_if #(.W(W), .DEPTH(DEPTH)) ifc ();

    stream_calc_q #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ifc.apply = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Driver: one accepted cycle worth of apply.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] v);
        @(negedge clk);
        ifc.apply = 1'b1;
        ifc.op    = o;
        ifc.in    = v;
        @(negedge clk);
        ifc.apply = 1'b0;
    endtask

    task automatic do_pop(input logic [W-1:0] expv);
        exp_q.push_back(expv);
        do_op(OP_POP, '0);
    endtask

    // Issue DIV/FRAC, keep apply high (as PUSH 99) while busy, measure busy length.
    task automatic run_div(input logic [2:0] o, input int exp_cycles, input string name);
        int n;
        n = 0;
        @(negedge clk);
        ifc.apply = 1'b1;
        ifc.op    = o;
        @(negedge clk);
        ifc.op = OP_PUSH;
        ifc.in = 8'd99;
        while (ifc.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        ifc.apply = 1'b0;
        check(name, n, exp_cycles);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && ifc.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_valid_unexpected: got out=%0d expected no pulse", ifc.out);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (ifc.out !== e) begin
                    errors++;
                    $display("FAIL out_value: got %0d expected %0d", ifc.out, e);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] mul_exp;
`ifdef STREAMCALC_SAT_EN
        mul_exp = 8'd255;
`else
        mul_exp = 8'd144;
`endif
        rst = 1'b0;
        ifc.apply = 1'b0;
        ifc.op = OP_ADD;
        ifc.in = '0;

        // 1: reset state, fill to full, overflow push
        do_reset();
        check("rst_count", 32'(ifc.count), 0);
        check("rst_empty", 32'(ifc.empty), 1);
        check("rst_full", 32'(ifc.full), 0);
        check("rst_out", 32'(ifc.out), 0);
        check("rst_busy", 32'(ifc.busy), 0);
        check("rst_err", 32'(ifc.err), 0);
        check("rst_err_code", 32'(ifc.err_code), 0);
        for (int i = 0; i < 8; i++) do_op(OP_PUSH, 8'd20);
        check("fill_full", 32'(ifc.full), 1);
        check("fill_err", 32'(ifc.err), 0);
        do_op(OP_PUSH, 8'd20);
        check("ovf_count", 32'(ifc.count), 8);
        check("ovf_full", 32'(ifc.full), 1);
        check("ovf_err", 32'(ifc.err), 1);
        check("ovf_err_code", 32'(ifc.err_code), 2);

        // 2: ADD, SUB, MUL
        do_reset();
        do_op(OP_PUSH, 8'd20);
        do_op(OP_PUSH, 8'd20);
        do_op(OP_ADD, '0);
        check("add_count", 32'(ifc.count), 1);
        do_pop(8'd40);
        check("pop_count", 32'(ifc.count), 0);
        check("pop_empty", 32'(ifc.empty), 1);
        do_op(OP_PUSH, 8'd20);
        do_op(OP_PUSH, 8'd3);
        do_op(OP_SUB, '0);
        do_pop(8'd17);
        do_op(OP_PUSH, 8'd20);
        do_op(OP_PUSH, 8'd20);
        do_op(OP_MUL, '0);
        do_pop(mul_exp);

        // 3: DIV and FRAC with apply held during busy
        do_op(OP_PUSH, 8'd20);
        do_op(OP_PUSH, 8'd3);
        run_div(OP_DIV, 8, "div_busy_cycles");
        check("div_count", 32'(ifc.count), 1);
        do_pop(8'd6);
        do_op(OP_PUSH, 8'd20);
        do_op(OP_PUSH, 8'd3);
        run_div(OP_FRAC, 16, "frac_busy_cycles");
        check("frac_count", 32'(ifc.count), 1);
        do_pop(8'd170);
        check("frac_err", 32'(ifc.err), 0);

        // 4: divide by zero
        do_op(OP_PUSH, 8'd255);
        do_op(OP_PUSH, 8'd0);
        do_op(OP_DIV, '0);
        check("div0_busy", 32'(ifc.busy), 0);
        check("div0_err", 32'(ifc.err), 1);
        check("div0_err_code", 32'(ifc.err_code), 3);
        check("div0_count", 32'(ifc.count), 2);

        // 5: bad opcode, pop on empty
        do_reset();
        do_op(OP_BAD, '0);
        check("badop_err", 32'(ifc.err), 1);
        check("badop_err_code", 32'(ifc.err_code), 0);
        do_reset();
        do_op(OP_POP, '0);
        check("popempty_err", 32'(ifc.err), 1);
        check("popempty_err_code", 32'(ifc.err_code), 1);
        check("popempty_out", 32'(ifc.out), 0);
        check("popempty_count", 32'(ifc.count), 0);

        // 6: reset in the middle of FRAC
        do_reset();
        do_op(OP_PUSH, 8'd200);
        do_op(OP_PUSH, 8'd7);
        @(negedge clk);
        ifc.apply = 1'b1;
        ifc.op    = OP_FRAC;
        @(negedge clk);
        ifc.apply = 1'b0;
        check("midrst_busy_before", 32'(ifc.busy), 1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy_now", 32'(ifc.busy), 0);
        check("midrst_count_now", 32'(ifc.count), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_count_after", 32'(ifc.count), 0);
        check("midrst_busy_after", 32'(ifc.busy), 0);
        check("midrst_empty_after", 32'(ifc.empty), 1);

        repeat (2) @(negedge clk);
        check("pending_outputs", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
